slos_prbs11_gen: RTL and testbench

- Transmit-side SLOS generator for USB4 lane training. Produces the serial PRBS11-based SLOS1/SLOS2 bit stream that the lane receiver's SLOS detector checks bit-for-bit.
- Sends a programmable number of back-to-back 2048-bit SLOS blocks on a start/stop handshake, then reports completion.
- Sits between the lane training FSM (control) and the serialiser/lane driver (data).

---
 rtl/usb4_slos_pkg.sv | 20 ++
 rtl/prbs11_lfsr.sv | 37 +++
 rtl/slos_prbs11_gen.sv | 154 +++++++++++++++
 tb/tb_slos_prbs11_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb4_slos_pkg.sv
// Shared USB4 SLOS definitions: PRBS11 seed/taps, block length and generator FSM states.
// Used by the transmit-side generator and the receive-side SLOS checker.
package usb4_slos_pkg;

  localparam logic [10:0] PRBS11_SEED   = 11'h400;
  localparam int unsigned SLOS_LEN      = 2048;
  localparam int unsigned PRBS11_TAP_HI = 10;
  localparam int unsigned PRBS11_TAP_LO = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FINISH
  } slos_gen_state_t;

  function automatic logic [10:0] prbs11_step(input logic [10:0] s);
    return {s[9:0], s[PRBS11_TAP_HI] ^ s[PRBS11_TAP_LO]};
  endfunction

endpackage

// File: rtl/prbs11_lfsr.sv
// 11-bit PRBS11 Fibonacci LFSR with load (to SEED), hold and advance controls.
// lfsr_nxt is the value the register takes at the next edge, so callers can register outputs without extra latency.
module prbs11_lfsr
  import usb4_slos_pkg::*;
#(
  parameter logic [10:0] SEED = PRBS11_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  output logic [10:0] lfsr_nxt
);

  logic [10:0] lfsr_q;
  logic [10:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (advance) begin
      lfsr_d = prbs11_step(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_nxt = lfsr_d;

endmodule

// File: rtl/slos_prbs11_gen.sv
// USB4 transmit-side SLOS1/SLOS2 generator: back-to-back 2048-bit PRBS11 blocks on a start/stop handshake.
// Optional macro SLOS_GEN_ERR_INJ_EN adds an err_inj port that flips the next emitted bit.
module slos_prbs11_gen
  import usb4_slos_pkg::*;
#(
  parameter logic [10:0] SEED  = PRBS11_SEED,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             slos_sel,
  input  logic [CNT_W-1:0] num_slos,
`ifdef SLOS_GEN_ERR_INJ_EN
  input  logic             err_inj,
`endif
  output logic             data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [10:0] LAST_BIT = 11'(SLOS_LEN - 1);

  slos_gen_state_t  state_q, state_d;
  logic [10:0]      bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [CNT_W-1:0] blk_target_q, blk_target_d;
  logic             sel_q, sel_d;
  logic             stop_pend_q, stop_pend_d;
  logic             data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             lfsr_load;
  logic             lfsr_adv;
  logic [10:0]      lfsr_nxt;
  logic [CNT_W:0]   blk_cnt_inc;
  logic             last_blk;

  prbs11_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .lfsr_nxt(lfsr_nxt)
  );

  assign blk_cnt_inc = {1'b0, blk_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign last_blk    = (blk_target_q != '0) && (blk_cnt_inc == {1'b0, blk_target_q});

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    blk_cnt_d    = blk_cnt_q;
    blk_target_d = blk_target_q;
    sel_d        = sel_q;
    stop_pend_d  = stop_pend_q;
    lfsr_load    = 1'b0;
    lfsr_adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SEND;
          sel_d        = slos_sel;
          blk_target_d = num_slos;
          bit_cnt_d    = '0;
          blk_cnt_d    = '0;
          stop_pend_d  = 1'b0;
          lfsr_load    = 1'b1;
        end
      end
      SEND: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        // bit_cnt is the index of the bit currently on data_out; bit 0 holds so the seed bit goes out twice
        lfsr_adv  = (bit_cnt_q != '0);
        bit_cnt_d = bit_cnt_q + 11'd1;
        if (bit_cnt_q == LAST_BIT) begin
          if (blk_cnt_q != '1) begin
            blk_cnt_d = blk_cnt_inc[CNT_W-1:0];
          end
          if (last_blk || stop_pend_q || stop) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state, so the first bit appears one cycle after start.
  always_comb begin
    data_out_d   = 1'b0;
    data_valid_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    if (state_d == SEND) begin
      data_valid_d = 1'b1;
      busy_d       = 1'b1;
      data_out_d   = lfsr_nxt[0] ^ sel_d;
`ifdef SLOS_GEN_ERR_INJ_EN
      if ((state_q == SEND) && err_inj) begin
        data_out_d = ~data_out_d;
      end
`endif
    end else if (state_d == FINISH) begin
      busy_d = 1'b1;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      blk_cnt_q    <= '0;
      blk_target_q <= '0;
      sel_q        <= 1'b0;
      stop_pend_q  <= 1'b0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      blk_cnt_q    <= blk_cnt_d;
      blk_target_q <= blk_target_d;
      sel_q        <= sel_d;
      stop_pend_q  <= stop_pend_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_slos_prbs11_gen.sv
// Self-checking bench for slos_prbs11_gen: randomized runs compared against a block-level SLOS stream model.
// Build with SLOS_GEN_ERR_INJ_EN defined to also exercise error injection.
module tb_slos_prbs11_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       slos_sel;
  logic [7:0] num_slos;
  logic       err_inj;
  logic       data_out;
  logic       data_valid;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  bit golden[2048];
  bit cap_q[$];
  bit exp_q[$];
  int cap_done, cap_gap, cap_both, cap_timeout;
  int cap_busy_at_done, cap_busy_after, cap_done_after;

  slos_prbs11_gen #(
    .SEED (11'h400),
    .CNT_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .slos_sel  (slos_sel),
    .num_slos  (num_slos),
`ifdef SLOS_GEN_ERR_INJ_EN
    .err_inj   (err_inj),
`endif
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference block: seed bit twice, then the remaining 2046 PRBS11 bits of the period.
  task automatic build_golden();
    int unsigned r;
    r = 11'h400;
    golden[0] = r[0];
    for (int k = 1; k < 2048; k++) begin
      golden[k] = r[0];
      r = ((r << 1) & 32'h7FF) | (((r >> 10) ^ (r >> 8)) & 32'h1);
    end
  endtask

  task automatic build_expected(input int nblk, input bit sel, input int ea, input int eb);
    exp_q.delete();
    for (int b = 0; b < nblk; b++)
      for (int k = 0; k < 2048; k++)
        exp_q.push_back(golden[k] ^ sel);
    if (ea >= 0 && ea + 1 < exp_q.size()) exp_q[ea + 1] = ~exp_q[ea + 1];
    if (eb >= 0 && eb + 1 < exp_q.size()) exp_q[eb + 1] = ~exp_q[eb + 1];
  endtask

  function automatic int count_diffs();
    int d;
    d = (cap_q.size() > exp_q.size()) ? cap_q.size() - exp_q.size() : exp_q.size() - cap_q.size();
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      if (cap_q[i] != exp_q[i]) d++;
    return d;
  endfunction

  function automatic int blocks_for(input int num, input int stop_at);
    int n;
    n = (stop_at >= 0) ? stop_at / 2048 + 1 : 1 << 30;
    if (num != 0 && num < n) n = num;
    return n;
  endfunction

  // Start a run and record the stream until done (or the cycle budget runs out).
  task automatic capture(input bit sel, input logic [7:0] num, input int stop_at,
                         input int err_a, input int err_b, input bit noise,
                         input bit err_at_start, input int budget);
    int idx;
    cap_q.delete();
    cap_done = 0; cap_gap = 0; cap_both = 0; cap_timeout = 1;
    cap_busy_at_done = 0; cap_busy_after = 1; cap_done_after = 1;
    @(negedge clk);
    start = 1'b1; slos_sel = sel; num_slos = num; err_inj = err_at_start;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0; err_inj = 1'b0;
      if (data_valid && done) cap_both++;
      if (data_valid) cap_q.push_back(data_out);
      if (done) begin
        cap_done = 1; cap_busy_at_done = busy; cap_timeout = 0;
        break;
      end
      if (!data_valid) cap_gap++;
      if (data_valid) begin
        idx = cap_q.size() - 1;
        if (idx == stop_at) stop = 1'b1;
        if (idx == err_a || idx == err_b) err_inj = 1'b1;
      end
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        slos_sel = 1'($urandom_range(0, 1));
        num_slos = 8'($urandom_range(0, 255));
      end
    end
    start = 1'b0; stop = 1'b0; err_inj = 1'b0;
    @(negedge clk);
    cap_busy_after = busy; cap_done_after = done;
  endtask

  task automatic check_run(input string tag);
    int d;
    d = count_diffs();
    n_cmp++; if (d !== 0) begin n_err++; $display("FAIL %s stream: %0d bits differ (got len %0d, expected len %0d)", tag, d, cap_q.size(), exp_q.size()); end
    n_cmp++; if (cap_timeout !== 0) begin n_err++; $display("FAIL %s done_timeout: got %0d expected 0", tag, cap_timeout); end
    n_cmp++; if (cap_gap !== 0) begin n_err++; $display("FAIL %s valid_gap: got %0d expected 0", tag, cap_gap); end
    n_cmp++; if (cap_both !== 0) begin n_err++; $display("FAIL %s valid_with_done: got %0d expected 0", tag, cap_both); end
    n_cmp++; if (cap_busy_at_done !== 1) begin n_err++; $display("FAIL %s busy_at_done: got %0d expected 1", tag, cap_busy_at_done); end
    n_cmp++; if (cap_busy_after !== 0 || cap_done_after !== 0) begin n_err++; $display("FAIL %s after_done busy/done: got %0d/%0d expected 0/0", tag, cap_busy_after, cap_done_after); end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; stop = 1'b0; slos_sel = 1'b0; num_slos = '0; err_inj = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({data_out, data_valid, busy, done} !== 4'b0000) begin n_err++; $display("FAIL reset_outputs: got %b expected 0000", {data_out, data_valid, busy, done}); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({data_out, data_valid, busy, done} !== 4'b0000) begin n_err++; $display("FAIL idle_outputs: got %b expected 0000", {data_out, data_valid, busy, done}); end
  endtask

  task automatic test_single_block();
    logic [3:0] first4;
    capture(1'b0, 8'd1, -1, -1, -1, 1'b0, 1'b0, 4000);
    first4 = (cap_q.size() >= 4) ? {cap_q[0], cap_q[1], cap_q[2], cap_q[3]} : 4'bxxxx;
    n_cmp++; if (first4 !== 4'b0010) begin n_err++; $display("FAIL slos1_first4: got %b expected 0010", first4); end
    n_cmp++; if (cap_q.size() !== 2048) begin n_err++; $display("FAIL slos1_len: got %0d expected 2048", cap_q.size()); end
    build_expected(1, 1'b0, -1, -1);
    check_run("slos1_single");
  endtask

  task automatic test_two_blocks();
    logic [3:0] first4;
    capture(1'b1, 8'd2, -1, -1, -1, 1'b0, 1'b0, 8000);
    first4 = (cap_q.size() >= 4) ? {cap_q[0], cap_q[1], cap_q[2], cap_q[3]} : 4'bxxxx;
    n_cmp++; if (first4 !== 4'b1101) begin n_err++; $display("FAIL slos2_first4: got %b expected 1101", first4); end
    n_cmp++; if (cap_q.size() !== 4096) begin n_err++; $display("FAIL slos2_len: got %0d expected 4096", cap_q.size()); end
    build_expected(2, 1'b1, -1, -1);
    check_run("slos2_two");
  endtask

  task automatic test_stop();
    bit s;
    s = 1'($urandom_range(0, 1));
    capture(s, 8'd0, 2 * 2048 + 100, -1, -1, 1'b0, 1'b0, 10000);
    n_cmp++; if (cap_q.size() !== 6144) begin n_err++; $display("FAIL stop_block3_len: got %0d expected 6144", cap_q.size()); end
    build_expected(3, s, -1, -1);
    check_run("stop_block3");
    capture(s, 8'd0, 2047, -1, -1, 1'b0, 1'b0, 6000);
    build_expected(1, s, -1, -1);
    check_run("stop_on_last_bit_cont");
    capture(~s, 8'd2, 4095, -1, -1, 1'b0, 1'b0, 8000);
    build_expected(2, ~s, -1, -1);
    check_run("stop_on_final_bit");
  endtask

  task automatic test_reset_mid_block();
    bit s;
    int d, seen_done;
    s = 1'($urandom_range(0, 1));
    cap_q.delete();
    @(negedge clk);
    start = 1'b1; slos_sel = s; num_slos = 8'd0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (data_valid) cap_q.push_back(data_out);
      if (cap_q.size() == 500) break;
      @(negedge clk);
    end
    build_expected(1, s, -1, -1);
    d = 0;
    for (int i = 0; i < 500; i++) if (i >= cap_q.size() || cap_q[i] != exp_q[i]) d++;
    n_cmp++; if (d !== 0) begin n_err++; $display("FAIL pre_reset_stream: got %0d bad bits expected 0", d); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({data_out, data_valid, busy, done} !== 4'b0000) begin n_err++; $display("FAIL mid_reset_outputs: got %b expected 0000", {data_out, data_valid, busy, done}); end
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || data_valid) seen_done++;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    if (done || busy || data_valid) seen_done++;
    n_cmp++; if (seen_done !== 0) begin n_err++; $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", seen_done); end
    s = 1'($urandom_range(0, 1));
    capture(s, 8'd1, -1, -1, -1, 1'b0, 1'b0, 4000);
    build_expected(1, s, -1, -1);
    check_run("restart_after_reset");
  endtask

  task automatic test_ignore_while_busy();
    bit s;
    int n;
    s = 1'($urandom_range(0, 1));
    n = $urandom_range(1, 2);
    capture(s, 8'(n), -1, -1, -1, 1'b1, 1'b0, 8000);
    build_expected(n, s, -1, -1);
    check_run("busy_noise");
  endtask

  task automatic test_random();
    bit s;
    int n, sa;
    for (int it = 0; it < 2; it++) begin
      s  = 1'($urandom_range(0, 1));
      n  = $urandom_range(0, 3);
      sa = (n == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(0, 2 * 2048 - 1) : -1;
      capture(s, 8'(n), sa, -1, -1, 1'b0, 1'b0, 10000);
      build_expected(blocks_for(n, sa), s, -1, -1);
      check_run("random_run");
    end
  endtask

`ifdef SLOS_GEN_ERR_INJ_EN
  task automatic test_err_inj();
    bit s;
    int eb;
    s = 1'($urandom_range(0, 1));
    capture(s, 8'd1, -1, 10, -1, 1'b0, 1'b1, 4000);
    build_expected(1, s, 10, -1);
    check_run("err_inj_bit10");
    eb = $urandom_range(20, 2040);
    capture(s, 8'd2, -1, 100, 2048 + eb, 1'b0, 1'b0, 8000);
    build_expected(2, s, 100, 2048 + eb);
    check_run("err_inj_two_pulses");
  endtask
`endif

  initial begin
    build_golden();
    test_reset();
    test_single_block();
    test_two_blocks();
    test_stop();
    test_reset_mid_block();
    test_ignore_while_busy();
    test_random();
`ifdef SLOS_GEN_ERR_INJ_EN
    test_err_inj();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
